// File: rtl/cs_rr_arbiter.sv
// cs_rr_arbiter: round-robin owner of a 3-to-8 active-low chip-select decoder with glitch-free setup/active/gap sequencing
module cs_rr_arbiter #(
    parameter int SETUP_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int MAX_HOLD     = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic       select_a_o,
    output logic       select_b_o,
    output logic       select_c_o,
    output logic       g1_en_o,
    output logic       g2a_en_n_o,
    output logic       g2b_en_n_o,
    output logic [7:0] gnt_n_o,
    output logic       busy_o,
    output logic       timeout_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, GAP} state_t;
    state_t     state, state_nxt;
    logic [2:0] sel, sel_nxt, last, last_nxt, win, idx;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] hold, hold_nxt;
    logic       found, hold_hit, done, to_nxt, act_nxt;
    assign {select_c_o, select_b_o, select_a_o} = sel;
    assign hold_hit = (MAX_HOLD != 0) && (hold == 8'(MAX_HOLD));
    assign done     = release_i || !req_i[sel] || hold_hit;
    assign act_nxt  = state_nxt == ACTIVE;
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && req_i[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        last_nxt  = last;
        cnt_nxt   = cnt;
        hold_nxt  = hold;
        to_nxt    = 1'b0;
        case (state)
            IDLE: if (found) begin
                state_nxt = SETUP;
                sel_nxt   = win;
                last_nxt  = win;
                cnt_nxt   = '0;
            end
            SETUP: if (cnt == 4'(SETUP_CYCLES - 1)) begin
                state_nxt = ACTIVE;
                hold_nxt  = 8'd1;
            end else cnt_nxt = cnt + 4'd1;
            ACTIVE: if (done) begin
                state_nxt = GAP;
                cnt_nxt   = '0;
                to_nxt    = hold_hit && !release_i && req_i[sel];
            end else hold_nxt = hold + 8'd1;
            GAP: if (cnt == 4'(GAP_CYCLES - 1)) state_nxt = IDLE;
                 else cnt_nxt = cnt + 4'd1;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            sel        <= '0;
            last       <= 3'd7;
            cnt        <= '0;
            hold       <= '0;
            g1_en_o    <= 1'b0;
            g2a_en_n_o <= 1'b1;
            g2b_en_n_o <= 1'b1;
            gnt_n_o    <= 8'hFF;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last       <= last_nxt;
            cnt        <= cnt_nxt;
            hold       <= hold_nxt;
            g1_en_o    <= act_nxt;
            g2a_en_n_o <= !act_nxt;
            g2b_en_n_o <= !act_nxt;
            gnt_n_o    <= act_nxt ? ~(8'h01 << sel_nxt) : 8'hFF;
            busy_o     <= state_nxt != IDLE;
            timeout_o  <= to_nxt;
        end
    end
endmodule

// File: tb/tb_cs_rr_arbiter.sv
// tb_cs_rr_arbiter: directed checks of sequencing, round-robin order, timeout, request drop and async reset
module tb_cs_rr_arbiter;
    logic       clk = 1'b0, rst_n;
    logic [7:0] req, req0;
    logic       rel;
    logic       sa, sb, sc, g1, g2a, g2b, busy, to;
    logic [7:0] gnt;
    logic       sa0, sb0, sc0, g10, g2a0, g2b0, busy0, to0;
    logic [7:0] gnt0;
    int         n_cmp = 0, n_bad = 0;
    logic       any_to;

    cs_rr_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .release_i(rel),
        .select_a_o(sa), .select_b_o(sb), .select_c_o(sc),
        .g1_en_o(g1), .g2a_en_n_o(g2a), .g2b_en_n_o(g2b),
        .gnt_n_o(gnt), .busy_o(busy), .timeout_o(to)
    );

    cs_rr_arbiter #(.MAX_HOLD(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .release_i(1'b0),
        .select_a_o(sa0), .select_b_o(sb0), .select_c_o(sc0),
        .g1_en_o(g10), .g2a_en_n_o(g2a0), .g2b_en_n_o(g2b0),
        .gnt_n_o(gnt0), .busy_o(busy0), .timeout_o(to0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " sel"}, {5'd0, sc, sb, sa}, 8'd0);
        chk({tag, " en"}, {5'd0, g1, g2a, g2b}, 8'b011);
        chk({tag, " gnt"}, gnt, 8'hFF);
        chk({tag, " busy"}, {7'd0, busy}, 8'd0);
        chk({tag, " timeout"}, {7'd0, to}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req0 = '0; rel = 1'b0;
        #12;
        chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        tick();
        // basic grant: cycle 0 is this IDLE cycle
        req = 8'h04;
        tick();
        chk("basic setup sel", {5'd0, sc, sb, sa}, 8'd2);
        chk("basic setup gnt", gnt, 8'hFF);
        chk("basic setup en", {5'd0, g1, g2a, g2b}, 8'b011);
        chk("basic setup busy", {7'd0, busy}, 8'd1);
        tick();
        chk("basic active en", {5'd0, g1, g2a, g2b}, 8'b100);
        chk("basic active gnt", gnt, 8'hFB);
        tick();
        tick();
        chk("basic hold gnt", gnt, 8'hFB);
        rel = 1'b1;
        tick();
        rel = 1'b0; req = '0;
        chk("basic gap gnt", gnt, 8'hFF);
        chk("basic gap en", {5'd0, g1, g2a, g2b}, 8'b011);
        chk("basic gap sel", {5'd0, sc, sb, sa}, 8'd2);
        chk("basic gap busy", {7'd0, busy}, 8'd1);
        tick();
        chk("basic idle busy", {7'd0, busy}, 8'd0);
        // round-robin from a fresh reset
        rst_n = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        tick();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr sel", {5'd0, sc, sb, sa}, 8'(i % 8));
            tick();
            chk("rr gnt", gnt, ~(8'h01 << (i % 8)));
            rel = 1'b1;
            tick();
            rel = 1'b0;
            chk("rr gap gnt", gnt, 8'hFF);
            tick();
        end
        // wrap search: make 6 the last owner, then 8'h41 wraps to 0
        req = 8'h40;
        tick();
        chk("wrap first sel", {5'd0, sc, sb, sa}, 8'd6);
        tick();
        req = 8'h41; rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        tick();
        chk("wrap sel", {5'd0, sc, sb, sa}, 8'd0);
        tick();
        chk("wrap gnt", gnt, 8'hFE);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        tick();
        chk("wrap back sel", {5'd0, sc, sb, sa}, 8'd6);
        tick();
        rel = 1'b1; req = '0;
        tick();
        rel = 1'b0;
        tick();
        // timeout with only requester 5
        req = 8'h20;
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to active gnt", gnt, 8'hDF);
            chk("to active timeout", {7'd0, to}, 8'd0);
        end
        tick();
        chk("to gap timeout", {7'd0, to}, 8'd1);
        chk("to gap gnt", gnt, 8'hFF);
        tick();
        chk("to idle timeout", {7'd0, to}, 8'd0);
        chk("to idle busy", {7'd0, busy}, 8'd0);
        tick();
        chk("to regrant sel", {5'd0, sc, sb, sa}, 8'd5);
        tick();
        chk("to regrant gnt", gnt, 8'hDF);
        req = '0;
        tick();
        chk("to drop timeout", {7'd0, to}, 8'd0);
        tick();
        // request drop at the 4th ACTIVE cycle of owner 3
        req = 8'h08;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("drop 4th gnt", gnt, 8'hF7);
        req = '0;
        tick();
        chk("drop gap gnt", gnt, 8'hFF);
        chk("drop gap timeout", {7'd0, to}, 8'd0);
        chk("drop gap busy", {7'd0, busy}, 8'd1);
        tick();
        // unlimited hold: 300 cycles with no timeout
        req0 = 8'h20;
        any_to = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            any_to |= to0;
        end
        chk("nolimit timeout", {7'd0, any_to}, 8'd0);
        chk("nolimit gnt", gnt0, 8'hDF);
        req0 = '0;
        // asynchronous reset in ACTIVE with owner 5
        req = 8'h20;
        tick();
        tick();
        chk("mid active gnt", gnt, 8'hDF);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("mid reset");
        req = 8'hA0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post reset sel", {5'd0, sc, sb, sa}, 8'd5);
        tick();
        chk("post reset gnt", gnt, 8'hDF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
